// File: rtl/compare_pipe.sv
`default_nettype none
// ============================================================================
// Module      : compare_pipe
// Description : Two-stage pipelined comparator for the execute stage.
//               Stage 1 captures operands/op/tag and derives eq, lt_s and
//               lt_u; stage 2 holds the final flag, result and tag.
//               Valid/ready handshake on both sides, fixed 2-cycle latency,
//               one operation per cycle.
//
//               Optional feature: define COMPARE_MINMAX_EN to build the
//               MIN_S/MAX_S/MIN_U/MAX_U ops (6-9) and the stage-2 operand
//               mux. Without it those codes behave like unknown ops.
//
// Ports       : clk, rst (async, active-high), flush (sync kill)
//               in_valid/in_ready, in_src1, in_src2, in_op[3:0], in_tag
//               out_valid/out_ready, out_flag, out_mask, out_result, out_tag
//
// Revision    : 1.0 - initial release
// ============================================================================
module compare_pipe #(
    parameter int WIDTH = 64,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_src1,
    input  logic [WIDTH-1:0] in_src2,
    input  logic [3:0]       in_op,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_flag,
    output logic [WIDTH-1:0] out_mask,
    output logic [WIDTH-1:0] out_result,
    output logic [TAG_W-1:0] out_tag
);

    localparam logic [3:0] c_OP_NE    = 4'd0;
    localparam logic [3:0] c_OP_EQ    = 4'd1;
    localparam logic [3:0] c_OP_GE_S  = 4'd2;
    localparam logic [3:0] c_OP_LT_S  = 4'd3;
    localparam logic [3:0] c_OP_LT_U  = 4'd4;
    localparam logic [3:0] c_OP_GE_U  = 4'd5;
`ifdef COMPARE_MINMAX_EN
    localparam logic [3:0] c_OP_MIN_S = 4'd6;
    localparam logic [3:0] c_OP_MAX_S = 4'd7;
    localparam logic [3:0] c_OP_MIN_U = 4'd8;
    localparam logic [3:0] c_OP_MAX_U = 4'd9;
`endif

    // Stage 1 state
    logic             r_s1_valid;
    logic [WIDTH-1:0] r_s1_src1;
    logic [WIDTH-1:0] r_s1_src2;
    logic [3:0]       r_s1_op;
    logic [TAG_W-1:0] r_s1_tag;

    // Stage 2 state (drives the outputs directly)
    logic             r_s2_valid;
    logic             r_s2_flag;
    logic [WIDTH-1:0] r_s2_result;
    logic [TAG_W-1:0] r_s2_tag;

    // Handshake
    logic w_s1_adv;
    logic w_accept;
    logic w_consume;

    // Stage 1 compare results
    logic             w_eq;
    logic             w_lt_s;
    logic             w_lt_u;
    logic             w_flag;
    logic [WIDTH-1:0] w_result;

    // s2 can take a new entry when empty or when its current entry leaves
    // this same cycle, so a stalled consumer backs up straight to in_ready.
    assign w_s1_adv  = r_s1_valid && (!r_s2_valid || out_ready);
    assign in_ready  = !rst && !flush && (!r_s1_valid || w_s1_adv);
    assign w_accept  = in_valid && in_ready;
    assign w_consume = r_s2_valid && out_ready;

    assign w_eq   = (r_s1_src1 == r_s1_src2);
    assign w_lt_s = ($signed(r_s1_src1) < $signed(r_s1_src2));
    assign w_lt_u = (r_s1_src1 < r_s1_src2);

`ifdef COMPARE_MINMAX_EN
    logic w_is_minmax;

    // For min/max the flag means "src1 selected"; ties select src1.
    always_comb begin
        w_flag      = 1'b0;
        w_is_minmax = 1'b0;
        case (r_s1_op)
            c_OP_NE:    w_flag = !w_eq;
            c_OP_EQ:    w_flag = w_eq;
            c_OP_GE_S:  w_flag = !w_lt_s;
            c_OP_LT_S:  w_flag = w_lt_s;
            c_OP_LT_U:  w_flag = w_lt_u;
            c_OP_GE_U:  w_flag = !w_lt_u;
            c_OP_MIN_S: begin w_is_minmax = 1'b1; w_flag = w_lt_s || w_eq; end
            c_OP_MAX_S: begin w_is_minmax = 1'b1; w_flag = !w_lt_s;        end
            c_OP_MIN_U: begin w_is_minmax = 1'b1; w_flag = w_lt_u || w_eq; end
            c_OP_MAX_U: begin w_is_minmax = 1'b1; w_flag = !w_lt_u;        end
            default:    w_flag = 1'b0;
        endcase
    end

    always_comb begin
        w_result = {{(WIDTH-1){1'b0}}, w_flag};
        if (w_is_minmax) begin
            w_result = w_flag ? r_s1_src1 : r_s1_src2;
        end
    end
`else
    always_comb begin
        w_flag = 1'b0;
        case (r_s1_op)
            c_OP_NE:   w_flag = !w_eq;
            c_OP_EQ:   w_flag = w_eq;
            c_OP_GE_S: w_flag = !w_lt_s;
            c_OP_LT_S: w_flag = w_lt_s;
            c_OP_LT_U: w_flag = w_lt_u;
            c_OP_GE_U: w_flag = !w_lt_u;
            default:   w_flag = 1'b0;
        endcase
    end

    assign w_result = {{(WIDTH-1){1'b0}}, w_flag};
`endif

    // Stage 1
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_src1  <= '0;
            r_s1_src2  <= '0;
            r_s1_op    <= '0;
            r_s1_tag   <= '0;
        end else if (flush) begin
            r_s1_valid <= 1'b0;
        end else if (w_accept) begin
            r_s1_valid <= 1'b1;
            r_s1_src1  <= in_src1;
            r_s1_src2  <= in_src2;
            r_s1_op    <= in_op;
            r_s1_tag   <= in_tag;
        end else if (w_s1_adv) begin
            r_s1_valid <= 1'b0;
        end
    end

    // Stage 2: data only loads on advance, so a stalled result stays put and
    // a flush leaves the last data visible with out_valid low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s2_valid  <= 1'b0;
            r_s2_flag   <= 1'b0;
            r_s2_result <= '0;
            r_s2_tag    <= '0;
        end else if (flush) begin
            r_s2_valid <= 1'b0;
        end else if (w_s1_adv) begin
            r_s2_valid  <= 1'b1;
            r_s2_flag   <= w_flag;
            r_s2_result <= w_result;
            r_s2_tag    <= r_s1_tag;
        end else if (w_consume) begin
            r_s2_valid <= 1'b0;
        end
    end

    assign out_valid  = r_s2_valid;
    assign out_flag   = r_s2_flag;
    assign out_mask   = {WIDTH{r_s2_flag}};
    assign out_result = r_s2_result;
    assign out_tag    = r_s2_tag;

endmodule
`default_nettype wire

// File: tb/tb_compare_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_compare_pipe
// Description : Directed self-checking bench for compare_pipe (WIDTH=64 and
//               WIDTH=8 instances). Honours COMPARE_MINMAX_EN for ops 6-9.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_compare_pipe;

    localparam logic [3:0] c_NE = 4'd0, c_EQ = 4'd1, c_GE_S = 4'd2, c_LT_S = 4'd3;
    localparam logic [3:0] c_LT_U = 4'd4, c_GE_U = 4'd5;
    localparam logic [3:0] c_MIN_S = 4'd6, c_MAX_S = 4'd7, c_MAX_U = 4'd9;
    localparam logic [63:0] c_NEG1 = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] c_NEG3 = 64'hFFFF_FFFF_FFFF_FFFD;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_src1, in_src2;
    logic [3:0]  in_op;
    logic [4:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic        out_flag;
    logic [63:0] out_mask, out_result;
    logic [4:0]  out_tag;

    logic        in_valid8, in_ready8, out_valid8, out_ready8, out_flag8;
    logic [7:0]  in_src1_8, in_src2_8, out_mask8, out_result8;
    logic [3:0]  in_op8;
    logic [4:0]  in_tag8, out_tag8;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    compare_pipe #(.WIDTH(64), .TAG_W(5)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_src1(in_src1), .in_src2(in_src2), .in_op(in_op), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_flag(out_flag),
        .out_mask(out_mask), .out_result(out_result), .out_tag(out_tag)
    );

    compare_pipe #(.WIDTH(8), .TAG_W(5)) dut8 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid8), .in_ready(in_ready8),
        .in_src1(in_src1_8), .in_src2(in_src2_8), .in_op(in_op8), .in_tag(in_tag8),
        .out_valid(out_valid8), .out_ready(out_ready8), .out_flag(out_flag8),
        .out_mask(out_mask8), .out_result(out_result8), .out_tag(out_tag8)
    );

    task automatic chk(input string nm, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", nm, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [3:0] op, input logic [63:0] a,
                         input logic [63:0] b, input logic [4:0] t);
        in_valid = v;
        in_op    = op;
        in_src1  = a;
        in_src2  = b;
        in_tag   = t;
    endtask

    task automatic expect_res(input string nm, input logic [63:0] res, input logic f,
                              input logic [4:0] t);
        chk({nm, ".valid"},  {63'd0, out_valid}, 64'd1);
        chk({nm, ".flag"},   {63'd0, out_flag},  {63'd0, f});
        chk({nm, ".result"}, out_result, res);
        chk({nm, ".mask"},   out_mask,   {64{f}});
        chk({nm, ".tag"},    {59'd0, out_tag}, {59'd0, t});
    endtask

    task automatic idle();
        drive(1'b0, 4'd0, 64'd0, 64'd0, 5'd0);
    endtask

    initial begin
        rst = 1'b0; flush = 1'b0; out_ready = 1'b1;
        idle();
        in_valid8 = 1'b0; in_src1_8 = 8'd0; in_src2_8 = 8'd0; in_op8 = 4'd0;
        in_tag8 = 5'd0; out_ready8 = 1'b1;
        #1 rst = 1'b1;

        // Reset state
        @(negedge clk); @(negedge clk);
        chk("rst.out_valid",  {63'd0, out_valid}, 64'd0);
        chk("rst.out_flag",   {63'd0, out_flag},  64'd0);
        chk("rst.out_mask",   out_mask,   64'd0);
        chk("rst.out_result", out_result, 64'd0);
        chk("rst.out_tag",    {59'd0, out_tag}, 64'd0);
        chk("rst.in_ready",   {63'd0, in_ready}, 64'd0);
        chk("rst.out_valid8", {63'd0, out_valid8}, 64'd0);
        rst = 1'b0;
        #1 chk("rst_rel.in_ready", {63'd0, in_ready}, 64'd1);

        // Signed/unsigned boundary: src1 = most negative, src2 = 1
        @(negedge clk); drive(1'b1, c_LT_S, 64'h8000_0000_0000_0000, 64'd1, 5'd1);
        @(negedge clk); chk("t1.empty", {63'd0, out_valid}, 64'd0);
                        drive(1'b1, c_LT_U, 64'h8000_0000_0000_0000, 64'd1, 5'd2);
        @(negedge clk); expect_res("t1.lt_s", 64'd1, 1'b1, 5'd1);
                        drive(1'b1, c_GE_U, 64'h8000_0000_0000_0000, 64'd1, 5'd3);
        @(negedge clk); expect_res("t1.lt_u", 64'd0, 1'b0, 5'd2); idle();
        @(negedge clk); expect_res("t1.ge_u", 64'd1, 1'b1, 5'd3);
        @(negedge clk); chk("t1.drained", {63'd0, out_valid}, 64'd0);

        // Back-to-back EQ, NE, GE_S
        @(negedge clk); drive(1'b1, c_EQ, 64'd5, 64'd5, 5'd4);
        @(negedge clk); drive(1'b1, c_NE, 64'd5, 64'd5, 5'd5);
        @(negedge clk); expect_res("t2.eq", 64'd1, 1'b1, 5'd4);
                        drive(1'b1, c_GE_S, c_NEG1, 64'd0, 5'd6);
        @(negedge clk); expect_res("t2.ne", 64'd0, 1'b0, 5'd5); idle();
        @(negedge clk); expect_res("t2.ge_s", 64'd0, 1'b0, 5'd6);
        @(negedge clk); chk("t2.drained", {63'd0, out_valid}, 64'd0);

        // Consumer stall for 4 cycles with 3 ops offered
        @(negedge clk); out_ready = 1'b0; drive(1'b1, c_EQ, 64'd1, 64'd1, 5'd7);
        #1 chk("t3.rdy0", {63'd0, in_ready}, 64'd1);
        @(negedge clk); chk("t3.empty", {63'd0, out_valid}, 64'd0);
                        drive(1'b1, c_LT_U, 64'd1, 64'd2, 5'd8);
        #1 chk("t3.rdy1", {63'd0, in_ready}, 64'd1);
        @(negedge clk); expect_res("t3.a0", 64'd1, 1'b1, 5'd7);
                        drive(1'b1, c_NE, 64'd1, 64'd1, 5'd9);
        #1 chk("t3.full0", {63'd0, in_ready}, 64'd0);
        @(negedge clk); expect_res("t3.a1", 64'd1, 1'b1, 5'd7);
                        chk("t3.full1", {63'd0, in_ready}, 64'd0);
        @(negedge clk); expect_res("t3.a2", 64'd1, 1'b1, 5'd7);
                        chk("t3.full2", {63'd0, in_ready}, 64'd0);
                        out_ready = 1'b1;
        #1 chk("t3.rdy_comb", {63'd0, in_ready}, 64'd1);
        @(negedge clk); expect_res("t3.b", 64'd1, 1'b1, 5'd8); idle();
        @(negedge clk); expect_res("t3.c", 64'd0, 1'b0, 5'd9);
        @(negedge clk); chk("t3.drained", {63'd0, out_valid}, 64'd0);

        // Min/max ops
        @(negedge clk); drive(1'b1, c_MIN_S, c_NEG3, 64'd2, 5'd10);
        @(negedge clk); drive(1'b1, c_MAX_U, c_NEG3, 64'd2, 5'd11);
`ifdef COMPARE_MINMAX_EN
        @(negedge clk); expect_res("t4.min_s", c_NEG3, 1'b1, 5'd10);
                        drive(1'b1, c_MAX_S, 64'd7, 64'd7, 5'd12);
        @(negedge clk); expect_res("t4.max_u", c_NEG3, 1'b1, 5'd11); idle();
        @(negedge clk); expect_res("t4.max_s", 64'd7, 1'b1, 5'd12);
`else
        @(negedge clk); expect_res("t4.min_s", 64'd0, 1'b0, 5'd10);
                        drive(1'b1, c_MAX_S, 64'd7, 64'd7, 5'd12);
        @(negedge clk); expect_res("t4.max_u", 64'd0, 1'b0, 5'd11); idle();
        @(negedge clk); expect_res("t4.max_s", 64'd0, 1'b0, 5'd12);
`endif
        @(negedge clk); chk("t4.drained", {63'd0, out_valid}, 64'd0);

        // Flush with both stages full
        @(negedge clk); out_ready = 1'b0; drive(1'b1, c_EQ, 64'd2, 64'd2, 5'd13);
        @(negedge clk); drive(1'b1, c_NE, 64'd2, 64'd3, 5'd14);
        @(negedge clk); expect_res("t5.pre", 64'd1, 1'b1, 5'd13);
                        flush = 1'b1; drive(1'b1, c_EQ, 64'd4, 64'd4, 5'd15);
        #1 chk("t5.flush_rdy", {63'd0, in_ready}, 64'd0);
        @(negedge clk); flush = 1'b0; idle(); out_ready = 1'b1;
                        chk("t5.valid", {63'd0, out_valid}, 64'd0);
                        chk("t5.held_tag", {59'd0, out_tag}, 64'd13);
                        chk("t5.held_res", out_result, 64'd1);
        #1 chk("t5.rdy_after", {63'd0, in_ready}, 64'd1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); chk("t5.no_emerge", {63'd0, out_valid}, 64'd0);
        end

        // Async reset mid-stream
        @(negedge clk); drive(1'b1, c_EQ, 64'd9, 64'd9, 5'd16);
        @(negedge clk); drive(1'b1, c_LT_U, 64'd1, 64'd2, 5'd17);
        @(negedge clk); expect_res("t6.pre", 64'd1, 1'b1, 5'd16); idle();
        #2 rst = 1'b1;
        #1 chk("t6.valid",  {63'd0, out_valid}, 64'd0);
           chk("t6.flag",   {63'd0, out_flag},  64'd0);
           chk("t6.mask",   out_mask,   64'd0);
           chk("t6.result", out_result, 64'd0);
           chk("t6.tag",    {59'd0, out_tag}, 64'd0);
           chk("t6.rdy",    {63'd0, in_ready}, 64'd0);
        @(negedge clk); rst = 1'b0;
        #1 chk("t6.rdy_rel", {63'd0, in_ready}, 64'd1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); chk("t6.no_partial", {63'd0, out_valid}, 64'd0);
        end

        // WIDTH=8: unknown op and signed boundary
        @(negedge clk); in_valid8 = 1'b1; in_op8 = 4'd15; in_src1_8 = 8'h12;
                        in_src2_8 = 8'h34; in_tag8 = 5'd21;
        @(negedge clk); in_op8 = c_LT_S; in_src1_8 = 8'h80; in_src2_8 = 8'h01;
                        in_tag8 = 5'd22;
        @(negedge clk); in_valid8 = 1'b0;
                        chk("w8.unk.valid",  {63'd0, out_valid8}, 64'd1);
                        chk("w8.unk.flag",   {63'd0, out_flag8},  64'd0);
                        chk("w8.unk.result", {56'd0, out_result8}, 64'd0);
                        chk("w8.unk.mask",   {56'd0, out_mask8},   64'd0);
                        chk("w8.unk.tag",    {59'd0, out_tag8},    64'd21);
        @(negedge clk); chk("w8.lts.flag",   {63'd0, out_flag8},  64'd1);
                        chk("w8.lts.result", {56'd0, out_result8}, 64'd1);
                        chk("w8.lts.mask",   {56'd0, out_mask8},   64'hFF);
                        chk("w8.lts.tag",    {59'd0, out_tag8},    64'd22);
        @(negedge clk); chk("w8.drained", {63'd0, out_valid8}, 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
